hidden_layer_seq: RTL and testbench

HIDDEN_LAYER_SEQ -- requirements
Module: hidden_layer_seq

---
 rtl/hl_pkg.sv | 29 ++
 rtl/hidden_layer_seq_if.sv | 38 +++
 rtl/hl_mac.sv | 65 ++++++
 rtl/hidden_layer_seq.sv | 106 ++++++++++
 tb/tb_hidden_layer_seq.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/hl_pkg.sv
// Shared types and constants for the sequential hidden-layer engine:
// FSM state encoding, default data width and saturation limit helpers.
package hl_pkg;

    localparam int HL_DW = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MAC,
        S_BIAS,
        S_OUT,
        S_DONE
    } hl_state_t;

    // Signed saturation bounds for a dw-bit two's complement result (dw <= 63).
    function automatic longint hl_sat_max(input int dw);
        return (longint'(1) <<< (dw - 1)) - 1;
    endfunction

    function automatic longint hl_sat_min(input int dw);
        return -(longint'(1) <<< (dw - 1));
    endfunction

    // Address width that stays legal when a dimension collapses to a single entry.
    function automatic int hl_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/hidden_layer_seq_if.sv
// Memory-read and result-stream bundle for hidden_layer_seq.
// master = the layer engine, slave = memories plus result consumer.
interface hidden_layer_seq_if
    import hl_pkg::*;
#(
    parameter int N_IN  = 4,
    parameter int N_OUT = 4,
    parameter int DW    = HL_DW
);
    localparam int IW = hl_width(N_IN);
    localparam int WW = hl_width(N_IN * N_OUT);
    localparam int NW = hl_width(N_OUT);

    logic          start;
    logic          busy;
    logic          done;
    logic [IW-1:0] in_addr;
    logic [WW-1:0] w_addr;
    logic [NW-1:0] b_addr;
    logic [DW-1:0] data_in;
    logic [DW-1:0] weight;
    logic [DW-1:0] bias;
    logic [DW-1:0] out_data;
    logic [NW-1:0] out_idx;
    logic          out_valid;
    logic          out_ready;

    modport master (
        input  start, data_in, weight, bias, out_ready,
        output busy, done, in_addr, w_addr, b_addr, out_data, out_idx, out_valid
    );

    modport slave (
        output start, data_in, weight, bias, out_ready,
        input  busy, done, in_addr, w_addr, b_addr, out_data, out_idx, out_valid
    );

endinterface

// File: rtl/hl_mac.sv
// Lossless multiply-accumulate for one neuron plus bias-add and signed saturation.
// HL_RELU_EN defined: negative saturated results are clamped to zero.
module hl_mac
    import hl_pkg::*;
#(
    parameter int N_IN = 4,
    parameter int DW   = HL_DW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 acc_en,
    input  logic                 bias_en,
    input  logic signed [DW-1:0] data_in,
    input  logic signed [DW-1:0] weight,
    input  logic signed [DW-1:0] bias,
    output logic signed [DW-1:0] result
);
    localparam int AW = 2 * DW + $clog2(N_IN) + 1;
    localparam logic signed [AW-1:0] SAT_MAX = AW'(hl_sat_max(DW));
    localparam logic signed [AW-1:0] SAT_MIN = AW'(hl_sat_min(DW));

    logic signed [2*DW-1:0] prod;
    logic signed [AW-1:0]   prod_ext;
    logic signed [AW-1:0]   acc;
    logic signed [AW-1:0]   bias_sum;
    logic signed [DW-1:0]   sat;
    logic signed [DW-1:0]   result_nxt;

    assign prod     = (2 * DW)'(data_in) * (2 * DW)'(weight);
    assign prod_ext = AW'(prod);
    assign bias_sum = acc + prod_ext + AW'(bias);

    always_comb begin
        // NOTE: default first so every path assigns sat and no latch is inferred.
        sat = bias_sum[DW-1:0];
        if (bias_sum > SAT_MAX) begin
            sat = SAT_MAX[DW-1:0];
        end else if (bias_sum < SAT_MIN) begin
            sat = SAT_MIN[DW-1:0];
        end
    end

`ifdef HL_RELU_EN
    assign result_nxt = sat[DW-1] ? '0 : sat;
`else
    assign result_nxt = sat;
`endif

    // The bias cycle folds in the final product, so result is ready as OUT begins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc    <= '0;
            result <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (acc_en) begin
            acc <= acc + prod_ext;
        end else if (bias_en) begin
            acc    <= bias_sum;
            result <= result_nxt;
        end
    end

endmodule

// File: rtl/hidden_layer_seq.sv
// Sequential fully-connected layer: one neuron at a time, one input per clock.
// Optional ReLU on the outputs via macro HL_RELU_EN (see hl_mac).
module hidden_layer_seq
    import hl_pkg::*;
#(
    parameter int N_IN  = 4,
    parameter int N_OUT = 4,
    parameter int DW    = HL_DW
) (
    input  logic               clk,
    input  logic               rst_n,
    hidden_layer_seq_if.master bus
);
    localparam int IW = hl_width(N_IN);
    localparam int WW = hl_width(N_IN * N_OUT);
    localparam int NW = hl_width(N_OUT);
    localparam logic [IW-1:0] I_LAST = IW'(N_IN - 1);
    localparam logic [NW-1:0] N_LAST = NW'(N_OUT - 1);

    hl_state_t            state;
    logic [IW-1:0]        i;
    logic [NW-1:0]        n;
    logic [WW-1:0]        w_addr;
    logic                 busy;
    logic                 done;
    logic                 out_valid;
    logic signed [DW-1:0] result;

    assign bus.in_addr   = i;
    assign bus.w_addr    = w_addr;
    assign bus.b_addr    = n;
    assign bus.out_idx   = n;
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = result;

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every branch sees pre-edge values.
        if (!rst_n) begin
            state     <= S_IDLE;
            i         <= '0;
            n         <= '0;
            w_addr    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: if (bus.start) begin
                    state  <= S_MAC;
                    busy   <= 1'b1;
                    i      <= '0;
                    n      <= '0;
                    w_addr <= '0;
                end
                S_MAC: if (i == I_LAST) begin
                    state <= S_BIAS;
                end else begin
                    i      <= i + IW'(1);
                    w_addr <= w_addr + WW'(1);
                end
                S_BIAS: begin
                    state     <= S_OUT;
                    out_valid <= 1'b1;
                end
                // Addresses are untouched here, so a stalled result keeps them stable.
                S_OUT: if (bus.out_ready) begin
                    out_valid <= 1'b0;
                    if (n == N_LAST) begin
                        state <= S_DONE;
                    end else begin
                        state  <= S_MAC;
                        n      <= n + NW'(1);
                        i      <= '0;
                        w_addr <= w_addr + WW'(1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Read data lags its address by one clock, so the MAC cycle issuing i=0 has nothing to add yet.
    hl_mac #(
        .N_IN (N_IN),
        .DW   (DW)
    ) u_mac (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     ((state == S_IDLE) || (state == S_OUT)),
        .acc_en  ((state == S_MAC) && (i != '0)),
        .bias_en (state == S_BIAS),
        .data_in (bus.data_in),
        .weight  (bus.weight),
        .bias    (bus.bias),
        .result  (result)
    );

endmodule

// File: tb/tb_hidden_layer_seq.sv
// Self-checking bench for hidden_layer_seq: table vectors, stall/start/reset
// sequences and random passes against a plain-arithmetic layer model.
`timescale 1ns/1ps
module tb_hidden_layer_seq;
    localparam int N_IN   = 4;
    localparam int N_OUT  = 4;
    localparam int DW     = 16;
    localparam int BUDGET = 200;
`ifdef HL_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    typedef struct {
        string                    name;
        logic [0:N_IN-1][DW-1:0]  d;
        logic [0:N_IN-1][DW-1:0]  w;
        logic [DW-1:0]            b;
        logic [DW-1:0]            exp_lin;
        logic [DW-1:0]            exp_relu;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks;
    int   failures;
    int   k;
    int   done_cnt;

    logic [DW-1:0] d_mem [N_IN];
    logic [DW-1:0] w_mem [N_IN*N_OUT];
    logic [DW-1:0] b_mem [N_OUT];
    logic [DW-1:0] res   [N_OUT];
    vec_t          vecs  [6];

    hidden_layer_seq_if #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW)) bus ();

    hidden_layer_seq #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    // Synchronous-read memories: data appears one clock after the address.
    always @(posedge clk) begin
        bus.data_in <= d_mem[bus.in_addr];
        bus.weight  <= w_mem[bus.w_addr];
        bus.bias    <= b_mem[bus.b_addr];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        k++;
        if (bus.done) done_cnt++;
    endtask

    // Dot product plus bias in wide arithmetic, then clamp to DW bits.
    function automatic logic [DW-1:0] model(input int nn);
        longint s;
        longint lim;
        lim = longint'(1) <<< (DW - 1);
        s = longint'($signed(b_mem[nn]));
        for (int ii = 0; ii < N_IN; ii++)
            s += longint'($signed(d_mem[ii])) * longint'($signed(w_mem[nn*N_IN+ii]));
        if (s > lim - 1) s = lim - 1;
        else if (s < -lim) s = -lim;
        if (RELU && s < 0) s = 0;
        return s[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] rnd(input bit full);
        int t;
        t = full ? int'($urandom) : int'($urandom_range(0, 200)) - 100;
        return t[DW-1:0];
    endfunction

    task automatic load_vec(input vec_t v);
        for (int ii = 0; ii < N_IN; ii++) d_mem[ii] = v.d[ii];
        for (int nn = 0; nn < N_OUT; nn++) begin
            b_mem[nn] = v.b;
            for (int ii = 0; ii < N_IN; ii++) w_mem[nn*N_IN+ii] = v.w[ii];
        end
    endtask

    // One full layer pass; stall = cycles out_ready is held low per result,
    // poke = toggle start randomly while the engine is busy.
    task automatic run_pass(input int stall, input bit poke);
        int entry_k;
        bit timed_out;
        timed_out = 1'b0;
        bus.out_ready = (stall == 0);
        @(negedge clk);
        bus.start = 1'b1;
        step();
        k = 0;
        done_cnt = 0;
        entry_k = 0;
        bus.start = poke;
        check("busy_after_start", bus.busy, 1);
        for (int nn = 0; nn < N_OUT && !timed_out; nn++) begin
            while (!bus.out_valid && k < BUDGET) begin
                step();
                if (poke) bus.start = 1'($urandom_range(0, 1));
            end
            if (!bus.out_valid) begin
                check("out_valid_timeout", bus.out_valid, 1);
                timed_out = 1'b1;
            end else begin
                check("mac_latency", k - entry_k, N_IN + 1);
                check("out_idx", bus.out_idx, nn);
                check("out_data", bus.out_data, model(nn));
                res[nn] = bus.out_data;
                for (int s = 0; s < stall; s++) begin
                    step();
                    if (poke) bus.start = 1'($urandom_range(0, 1));
                    check("stall_valid", bus.out_valid, 1);
                    check("stall_data", bus.out_data, model(nn));
                    check("stall_idx", bus.out_idx, nn);
                    check("stall_in_addr", bus.in_addr, N_IN - 1);
                    check("stall_w_addr", bus.w_addr, nn * N_IN + N_IN - 1);
                    check("stall_b_addr", bus.b_addr, nn);
                end
                bus.out_ready = 1'b1;
                step();
                bus.out_ready = (stall == 0);
                entry_k = k;
                if (nn < N_OUT - 1) begin
                    check("next_mac_valid", bus.out_valid, 0);
                    check("next_mac_in_addr", bus.in_addr, 0);
                    check("next_mac_w_addr", bus.w_addr, (nn + 1) * N_IN);
                    check("next_mac_b_addr", bus.b_addr, nn + 1);
                end
            end
        end
        bus.start = 1'b0;
        check("done_state_busy", bus.busy, 1);
        check("done_state_done", bus.done, 0);
        step();
        check("done_pulse", bus.done, 1);
        check("idle_busy", bus.busy, 0);
        if (stall == 0) check("start_to_done", k, N_OUT * (N_IN + 2) + 1);
        step();
        check("done_one_cycle", bus.done, 0);
        check("done_count", done_cnt, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        checks = 0;
        failures = 0;
        k = 0;
        done_cnt = 0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.out_ready = 1'b1;
        for (int ii = 0; ii < N_IN; ii++) d_mem[ii] = '0;
        for (int ii = 0; ii < N_IN * N_OUT; ii++) w_mem[ii] = '0;
        for (int nn = 0; nn < N_OUT; nn++) begin
            b_mem[nn] = '0;
            res[nn] = '0;
        end

        vecs[0] = '{"dot_1234",  {16'h0001, 16'h0001, 16'h0001, 16'h0001}, {16'h0001, 16'h0002, 16'h0003, 16'h0004}, 16'h0005, 16'h000F, 16'h000F};
        vecs[1] = '{"sat_pos",   {16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF}, {16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF}, 16'h7FFF, 16'h7FFF, 16'h7FFF};
        vecs[2] = '{"sat_neg",   {16'h8000, 16'h8000, 16'h8000, 16'h8000}, {16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF}, 16'h0000, 16'h8000, 16'h0000};
        vecs[3] = '{"minus4",    {16'h0001, 16'h0001, 16'h0001, 16'h0001}, {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, 16'h0000, 16'hFFFC, 16'h0000};
        vecs[4] = '{"mixed_neg", {16'h0002, 16'hFFFD, 16'h0004, 16'hFFFB}, {16'h000A, 16'h000A, 16'h000A, 16'h000A}, 16'hFFFF, 16'hFFEB, 16'h0000};
        vecs[5] = '{"mixed_pos", {16'h0064, 16'h00C8, 16'hFFCE, 16'h0007}, {16'h0003, 16'hFFFF, 16'h0002, 16'h0004}, 16'h03E8, 16'h0404, 16'h0404};

        step();
        step();
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_valid", bus.out_valid, 0);
        check("rst_data", bus.out_data, 0);
        check("rst_idx", bus.out_idx, 0);
        check("rst_addr", {bus.in_addr, bus.w_addr, bus.b_addr}, 0);
        rst_n = 1'b1;
        step();

        for (int t = 0; t < 6; t++) begin
            load_vec(vecs[t]);
            run_pass(0, 1'b0);
            check({"tbl_n0_", vecs[t].name}, res[0], RELU ? vecs[t].exp_relu : vecs[t].exp_lin);
            check({"tbl_n3_", vecs[t].name}, res[N_OUT-1], RELU ? vecs[t].exp_relu : vecs[t].exp_lin);
        end

        // Distinct weights per neuron, three-cycle back-pressure on every result.
        load_vec(vecs[0]);
        for (int nn = 0; nn < N_OUT; nn++)
            for (int ii = 0; ii < N_IN; ii++) w_mem[nn*N_IN+ii] = DW'(ii + 1 + nn);
        run_pass(3, 1'b0);

        // Stray start pulses while busy must not restart or reorder the pass.
        run_pass(0, 1'b1);
        run_pass(2, 1'b1);

        // Reset in the middle of neuron 2's MAC, then a clean pass from neuron 0.
        load_vec(vecs[0]);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        k = 0;
        while (k < 2 * (N_IN + 2) + 2) step();
        check("pre_rst_b_addr", bus.b_addr, 2);
        check("pre_rst_busy", bus.busy, 1);
        check("pre_rst_valid", bus.out_valid, 0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_valid", bus.out_valid, 0);
        check("mid_rst_done", bus.done, 0);
        check("mid_rst_data", bus.out_data, 0);
        check("mid_rst_idx", bus.out_idx, 0);
        check("mid_rst_in_addr", bus.in_addr, 0);
        check("mid_rst_w_addr", bus.w_addr, 0);
        check("mid_rst_b_addr", bus.b_addr, 0);
        for (int nn = 0; nn < N_OUT; nn++) res[nn] = '1;
        run_pass(0, 1'b0);
        check("post_rst_n0", res[0], 16'h000F);

        for (int r = 0; r < 8; r++) begin
            for (int ii = 0; ii < N_IN; ii++) d_mem[ii] = rnd(r % 2 == 1);
            for (int ii = 0; ii < N_IN * N_OUT; ii++) w_mem[ii] = rnd(r % 2 == 1);
            for (int nn = 0; nn < N_OUT; nn++) b_mem[nn] = rnd(r % 4 == 3);
            run_pass(int'($urandom_range(0, 2)), r % 3 == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
